div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 119 +++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit RV32M divider: one restoring shift-subtract step per cycle,
// with single-cycle fast paths for divide-by-zero and signed overflow.
module div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        flush,
   input  logic [1:0]  sel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        zero
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic        is_rem;
   logic        neg_q;
   logic        neg_r;

   logic        a_neg, b_neg, div_zero, ovf;
   logic [31:0] a_mag, b_mag, fast_res;
   logic [32:0] shifted, diff;
   logic [31:0] nxt_rem, nxt_quo, fin_q, fin_r;

   // Operand decode at acceptance and one restoring division step.
   always_comb begin
      a_neg    = ~sel[0] & a[31];
      b_neg    = ~sel[0] & b[31];
      a_mag    = a_neg ? (32'd0 - a) : a;
      b_mag    = b_neg ? (32'd0 - b) : b;
      div_zero = (b == 32'd0);
      ovf      = ~sel[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
      if (div_zero) begin
         fast_res = sel[1] ? a : 32'hFFFF_FFFF;
      end else begin
         fast_res = sel[1] ? 32'h0000_0000 : 32'h8000_0000;
      end
      shifted = {rem_q, quo_q[31]};
      diff    = shifted - {1'b0, dvs_q};
      nxt_rem = diff[32] ? shifted[31:0] : diff[31:0];
      nxt_quo = {quo_q[30:0], ~diff[32]};
      fin_q   = neg_q ? (32'd0 - nxt_quo) : nxt_quo;
      fin_r   = neg_r ? (32'd0 - nxt_rem) : nxt_rem;
   end

   // Control FSM with registered busy/done/result and the working registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= 32'd0;
         cnt    <= 6'd0;
         rem_q  <= 32'd0;
         quo_q  <= 32'd0;
         dvs_q  <= 32'd0;
         is_rem <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= 6'd0;
      end else begin
         case (state)
            CALC: begin
               rem_q <= nxt_rem;
               quo_q <= nxt_quo;
               cnt   <= cnt + 6'd1;
               if (cnt == 6'd31) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= is_rem ? fin_r : fin_q;
               end else begin
                  state <= CALC;
               end
            end
            IDLE, DONE: begin
               done <= 1'b0;
               if (start && (div_zero || ovf)) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  result <= fast_res;
               end else if (start) begin
                  state  <= CALC;
                  busy   <= 1'b1;
                  cnt    <= 6'd0;
                  rem_q  <= 32'd0;
                  quo_q  <= a_mag;
                  dvs_q  <= b_mag;
                  is_rem <= sel[1];
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign zero = (result == 32'd0);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: cycle-level behavioural model checked every
// cycle, plus hand-computed result and latency expectations.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, done, zero;
   logic [31:0] result;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   div_unit dut (
      .clk(clk), .reset(reset), .start(start), .flush(flush), .sel(sel),
      .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference result: {fast_path, value} from RV32M arithmetic rules.
   function automatic logic [32:0] ref_op(input logic [1:0] s, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      logic [31:0] v;
      if (y == 32'd0) return {1'b1, (s[1] ? x : 32'hFFFF_FFFF)};
      if (!s[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
         return {1'b1, (s[1] ? 32'h0000_0000 : 32'h8000_0000)};
      if (s[0]) begin
         sx = {32'd0, x};
         sy = {32'd0, y};
      end else begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
      end
      v = s[1] ? 32'(sx % sy) : 32'(sx / sy);
      return {1'b0, v};
   endfunction

   logic        m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b1;
   logic [31:0] m_res = 32'd0, m_pend = 32'd0;
   int          m_left = 0;

   always @(posedge clk) begin
      logic [32:0] r;
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_res = 32'd0; m_valid = 1'b1; m_left = 0;
      end else if (flush) begin
         m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_left = 0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0; m_done = 1'b1; m_res = m_pend; m_valid = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            r = ref_op(sel, a, b);
            if (r[32]) begin
               m_done = 1'b1; m_res = r[31:0]; m_valid = 1'b1;
            end else begin
               m_busy = 1'b1; m_left = 32; m_pend = r[31:0]; m_valid = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(m_done));
         if (m_valid) begin
            check("result", result, m_res);
            check("zero", 32'(zero), 32'(m_res == 32'd0));
         end
      end
   end

   task automatic launch(input logic [1:0] s, input logic [31:0] x, input logic [31:0] y);
      @(posedge clk); #1;
      sel = s; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom; sel = 2'($urandom_range(0, 3));
   endtask

   // Returns at the negedge of the done cycle (or after the bound expires).
   task automatic wait_done(input string nm, input logic [31:0] exp_res, input int exp_lat, input int cyc0);
      int cyc = cyc0;
      bit found = 1'b0;
      while (!found && cyc <= 40) begin
         @(negedge clk);
         if (done) found = 1'b1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      check({nm, " latency"}, 32'(cyc), 32'(exp_lat));
      check({nm, " result"}, result, exp_res);
   endtask

   task automatic count_no_done(input string nm);
      int nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) nd++;
      end
      check({nm, " done pulses"}, 32'(nd), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset result", result, 32'd0);
      check("reset zero", 32'(zero), 32'd1);

      launch(2'b01, 32'd100, 32'd7);          wait_done("divu 100/7", 32'd14, 33, 1);
      launch(2'b11, 32'd100, 32'd7);          wait_done("remu 100/7", 32'd2, 33, 1);
      check("remu zero", 32'(zero), 32'd0);
      launch(2'b00, 32'hFFFF_FFF9, 32'd2);    wait_done("div -7/2", 32'hFFFF_FFFD, 33, 1);
      launch(2'b10, 32'hFFFF_FFF9, 32'd2);    wait_done("rem -7/2", 32'hFFFF_FFFF, 33, 1);
      launch(2'b10, 32'd6, 32'd3);            wait_done("rem 6/3", 32'd0, 33, 1);
      check("rem 6/3 zero", 32'(zero), 32'd1);
      launch(2'b00, 32'd5, 32'd0);            wait_done("div 5/0", 32'hFFFF_FFFF, 1, 1);
      launch(2'b11, 32'd5, 32'd0);            wait_done("remu 5/0", 32'd5, 1, 1);
      launch(2'b00, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div ovf", 32'h8000_0000, 1, 1);
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("rem ovf", 32'd0, 1, 1);
      launch(2'b01, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("divu big", 32'd0, 33, 1);
      launch(2'b00, 32'd100, 32'hFFFF_FFF9);  wait_done("div 100/-7", 32'hFFFF_FFF2, 33, 1);

      // Start pulse mid-calculation must be ignored.
      launch(2'b01, 32'd100, 32'd7);
      repeat (4) begin @(posedge clk); #1; end
      sel = 2'b01; a = 32'd200; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("ignored start", 32'd14, 33, 6);

      // Start during the done cycle is accepted back-to-back.
      sel = 2'b01; a = 32'd1000; b = 32'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      wait_done("back-to-back", 32'd100, 33, 1);

      // Flush in cycle 10.
      launch(2'b01, 32'd12345, 32'd6);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush busy", 32'(busy), 32'd0);
      count_no_done("flush");

      // Reset in cycle 20.
      launch(2'b00, 32'hFFFF_0000, 32'd3);
      repeat (19) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid reset busy", 32'(busy), 32'd0);
      check("mid reset done", 32'(done), 32'd0);
      check("mid reset result", result, 32'd0);
      check("mid reset zero", 32'(zero), 32'd1);
      count_no_done("mid reset");

      launch(2'b00, 32'hFFFF_FF9C, 32'd7);    wait_done("div -100/7", 32'hFFFF_FFF2, 33, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
